// File: rtl/spi_master_if.sv
// Host-side request/response bundle for spi_master.
// The host drives through the master modport; spi_master takes the slave modport.
interface spi_master_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_cmd;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;

    modport master (
        output req_valid,
        output req_cmd,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/spi_master.sv
// 10-bit command/address SPI frame sequencer with optional read-data turnaround and receive.
// Optional macro SPI_MASTER_ORDER_CHK_EN enables read-address/read-data ordering checks on err.
module spi_master #(
    parameter int TURN_CYC = 2,
    parameter int GAP_CYC  = 1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus,
    output logic         SS_n,
    output logic         MOSI,
    input  logic         MISO,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEL,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    state_t     state;
    logic [9:0] frame;
    logic [6:0] shreg;
    logic [3:0] bit_cnt;
    logic [3:0] turn_cnt;
    logic [3:0] gap_cnt;
    logic       ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       ss_q;
    logic       mosi_q;
    logic       busy_q;
    logic       accept;
    logic       order_bad;

`ifdef SPI_MASTER_ORDER_CHK_EN
    logic rd_pend;
    logic err_q;

    assign order_bad = ((bus.req_cmd == 2'b11) && !rd_pend) ||
                       ((bus.req_cmd == 2'b10) &&  rd_pend);
    assign err       = err_q;
`else
    assign order_bad = 1'b0;
    assign err       = 1'b0;
`endif

    // ready is forced low for as long as rst is held, not just from the next edge
    assign bus.req_ready = ready_q & ~rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign SS_n          = ss_q;
    assign MOSI          = mosi_q;
    assign busy          = busy_q;
    assign accept        = bus.req_valid & ready_q;

    // Payload capture and receive shift register carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            frame <= {bus.req_cmd, bus.req_data};
        end
        if (state == RECV) begin
            shreg <= {shreg[5:0], MISO};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            bit_cnt     <= 4'd0;
            turn_cnt    <= 4'd0;
            gap_cnt     <= 4'd0;
`ifdef SPI_MASTER_ORDER_CHK_EN
            rd_pend     <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef SPI_MASTER_ORDER_CHK_EN
            err_q       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (order_bad) begin
                            // Rejected command: one GAP cycle with SS_n kept high
                            state   <= GAP;
                            gap_cnt <= 4'd0;
`ifdef SPI_MASTER_ORDER_CHK_EN
                            err_q   <= 1'b1;
`endif
                        end else begin
                            state  <= START;
                            ss_q   <= 1'b0;
                            mosi_q <= 1'b0;
                        end
                    end
                end
                START: begin
                    state  <= SEL;
                    mosi_q <= frame[9];
                end
                SEL: begin
                    state   <= SHIFT;
                    mosi_q  <= frame[9];
                    bit_cnt <= 4'd9;
                end
                SHIFT: begin
                    if (bit_cnt == 4'd0) begin
                        mosi_q <= 1'b0;
                        if (frame[9:8] == 2'b11) begin
                            state    <= TURN;
                            turn_cnt <= 4'(TURN_CYC - 1);
                        end else begin
                            state   <= GAP;
                            gap_cnt <= 4'(GAP_CYC - 1);
                            ss_q    <= 1'b1;
`ifdef SPI_MASTER_ORDER_CHK_EN
                            if (frame[9:8] == 2'b10) begin
                                rd_pend <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        mosi_q  <= frame[bit_cnt - 4'd1];
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                TURN: begin
                    if (turn_cnt == 4'd0) begin
                        state   <= RECV;
                        bit_cnt <= 4'd7;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                RECV: begin
                    if (bit_cnt == 4'd0) begin
                        state       <= GAP;
                        gap_cnt     <= 4'(GAP_CYC - 1);
                        ss_q        <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= {shreg, MISO};
`ifdef SPI_MASTER_ORDER_CHK_EN
                        rd_pend     <= 1'b0;
`endif
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ss_q    <= 1'b1;
                    mosi_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
